// File: rtl/alu_result_serializer.sv
// Buffers ALU results in a small FIFO and streams each one out as OUT_WIDTH-bit
// slices, least significant slice first, over a valid/ready handshake.
module alu_result_serializer #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_WIDTH-1:0]  IN_DATA,
    input  logic                 IN_VALID,
    output logic [OUT_WIDTH-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic                 FIFO_FULL,
    output logic                 DROP_ERR
);

    localparam int unsigned SLICES = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    logic [IN_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 full_q;
    logic                 busy_q;
    logic                 drop_q;

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;

    logic                 last_slice;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [IN_WIDTH-1:0]  head;
    logic [IN_WIDTH-1:0]  next_head;

    function automatic logic [OUT_WIDTH-1:0] slice_of(
        input logic [IN_WIDTH-1:0] word,
        input logic [IDX_W-1:0]    idx
    );
        return OUT_WIDTH'(word >> (32'(idx) * OUT_WIDTH));
    endfunction

    // A push while full is only accepted when the head leaves on the same edge.
    always_comb begin
        last_slice = (idx_q == IDX_W'(SLICES - 1));
        pop        = (state_q == SEND) && OUT_READY && last_slice;
        push       = IN_VALID && (!full_q || pop);
        drop       = IN_VALID && full_q && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        head       = mem_q[rd_ptr_q];
        // With a single entry left, the only follower is the result arriving now.
        next_head  = (count_q == CNT_W'(1)) ? IN_DATA : mem_q[rd_ptr_q + PTR_W'(1)];
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    // FIFO bookkeeping and status flags; SEND always has a head entry, so busy follows count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            busy_q   <= (count_d != '0);
            drop_q   <= drop_q | drop;
        end
    end

    // Slice sequencer with registered valid and data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= SEND;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= slice_of(head, IDX_W'(0));
                    end
                end
                SEND: begin
                    if (OUT_READY) begin
                        if (!last_slice) begin
                            idx_q      <= idx_q + IDX_W'(1);
                            out_data_q <= slice_of(head, idx_q + IDX_W'(1));
                        end else begin
                            idx_q <= '0;
                            if (count_d != '0) begin
                                out_data_q <= slice_of(next_head, IDX_W'(0));
                            end else begin
                                state_q     <= IDLE;
                                out_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign FIFO_FULL = full_q;
    assign DROP_ERR  = drop_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer: accepted results queue their
// expected slices; every slice handshake pops and compares.
`timescale 1ns/1ps
module tb_alu_result_serializer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SLICES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        fifo_full;
    logic        drop_err;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  exp_q[$];
    int          mdl_cnt  = 0;
    int          mdl_idx  = 0;
    logic        mdl_drop = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = '0;
    logic        pop_m;
    logic [7:0]  exp_b;

    alu_result_serializer #(
        .IN_WIDTH (16),
        .OUT_WIDTH(8),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .IN_DATA  (in_data),
        .IN_VALID (in_valid),
        .OUT_DATA (out_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .BUSY     (busy),
        .FIFO_FULL(fifo_full),
        .DROP_ERR (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, just after the falling edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        @(negedge clk); #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 200) begin
            cycle(1'b0, 16'h0, 1'b1);
            w++;
        end
        check("drain_done", 32'(w < 200), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1);
    endtask

    // Reference model and scoreboard, sampled well before the next rising edge.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_q.delete();
            mdl_cnt   = 0;
            mdl_idx   = 0;
            mdl_drop  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(mdl_cnt != 0));
            check("fifo_full", 32'(fifo_full), 32'(mdl_cnt == DEPTH));
            check("drop_err", 32'(drop_err), 32'(mdl_drop));
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            pop_m = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_slice", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("slice", 32'(out_data), 32'(exp_b));
                end
                if (mdl_idx == SLICES - 1) begin
                    mdl_idx = 0;
                    pop_m   = 1'b1;
                end else begin
                    mdl_idx++;
                end
            end
            if (in_valid) begin
                if (mdl_cnt < DEPTH || pop_m) begin
                    for (int s = 0; s < SLICES; s++) exp_q.push_back(in_data[s*8 +: 8]);
                    mdl_cnt++;
                end else begin
                    mdl_drop = 1'b1;
                end
            end
            if (pop_m) mdl_cnt--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Single result: latency and byte order
        cycle(1'b1, 16'hA5C3, 1'b1);
        cycle(1'b0, 16'h0, 1'b1); #1;
        check("single_lat_valid", 32'(out_valid), 32'd0);
        check("single_lat_busy", 32'(busy), 32'd1);
        cycle(1'b0, 16'h0, 1'b1); #1;
        check("single_lo_valid", 32'(out_valid), 32'd1);
        check("single_lo", 32'(out_data), 32'hC3);
        cycle(1'b0, 16'h0, 1'b1); #1;
        check("single_hi", 32'(out_data), 32'hA5);
        cycle(1'b0, 16'h0, 1'b1); #1;
        check("single_end_valid", 32'(out_valid), 32'd0);
        check("single_end_busy", 32'(busy), 32'd0);
        check("single_end_drop", 32'(drop_err), 32'd0);
        drain();

        // Back-pressure: slice held stable while ready is low
        cycle(1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 1'b0); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h34);
        end
        drain();

        // Overflow: fifth result dropped
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0);
        cycle(1'b1, 16'h0005, 1'b0); #1;
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_no_drop_yet", 32'(drop_err), 32'd0);
        cycle(1'b0, 16'h0, 1'b0); #1;
        check("ovf_drop", 32'(drop_err), 32'd1);
        drain();

        // Reset while the low byte of the 2nd of 3 results is pending
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);
        @(negedge clk); #1;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        check("mid_pre_data", 32'(out_data), 32'h22);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        check("mid_rst_drop", 32'(drop_err), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 16'h00FF, 1'b1);
        drain();

        // Streaming with pointer wrap-around: output stays valid throughout
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    cycle(1'b1, 16'h0100 + 16'(i), 1'b1);
                    cycle(1'b0, 16'h0, 1'b1);
                end
            end
            begin
                int w;
                int run;
                w = 0;
                run = 0;
                while (!out_valid && w < 20) begin
                    @(negedge clk); #3;
                    w++;
                end
                while (out_valid && run < 40) begin
                    run++;
                    @(negedge clk); #3;
                end
                check("stream_run", 32'(run), 32'd20);
            end
        join
        drain();
        check("stream_drop", 32'(drop_err), 32'd0);

        // Full FIFO with push on the same edge the head's high byte leaves
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        cycle(1'b0, 16'h0, 1'b1); #1;
        check("fullpop_drop", 32'(drop_err), 32'd0);
        check("fullpop_full", 32'(fifo_full), 32'd1);
        drain();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
